// File: rtl/medidor_eco_pkg.sv
// Shared constants and FSM encoding for the ultrasonic ranging path.
package medidor_eco_pkg;

  // Defaults for a 50 MHz clock; the trigger timer uses the same values
  localparam int unsigned CYC_PER_CM_50M = 2900;     // 58 us per centimetre
  localparam int unsigned TIMEOUT_50M    = 1900000;  // 38 ms echo window

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } estado_t;

endpackage

// File: rtl/medidor_eco_sincronizador.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous sensor line.
module sincronizador (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic echo_s,
  output logic rise
);

  logic meta;
  logic echo_q;

  // Metastability filter followed by a one-cycle history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      echo_s <= 1'b0;
      echo_q <= 1'b0;
    end else begin
      meta   <= async_in;
      echo_s <= meta;
      echo_q <= echo_s;
    end
  end

  // Edge pulse decoded purely from flops, so it is glitch-free
  assign rise = echo_s & ~echo_q;

endmodule

// File: rtl/medidor_eco.sv
// Echo pulse-width meter: measures echo-high cycles and converts to centimetres.
module medidor_eco
  import medidor_eco_pkg::*;
#(
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned DIST_W     = 9,
  parameter int unsigned CYC_PER_CM = CYC_PER_CM_50M,
  parameter int unsigned TIMEOUT    = TIMEOUT_50M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              echo,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  width,
  output logic [DIST_W-1:0] dist_cm
);

  localparam int unsigned SUB_W = (CYC_PER_CM > 2) ? $clog2(CYC_PER_CM) : 1;

  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYC_PER_CM - 1);

  estado_t            state;
  logic [SUB_W-1:0]   sub;
  logic [CNT_W-1:0]   tcnt;
  logic               echo_s;
  logic               rise;

  sincronizador u_sinc (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (echo),
    .echo_s   (echo_s),
    .rise     (rise)
  );

  // Measurement FSM; distance is built incrementally so no divider is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      width   <= '0;
      dist_cm <= '0;
      sub     <= '0;
      tcnt    <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (init) begin
            width   <= '0;
            dist_cm <= '0;
            sub     <= '0;
            tcnt    <= '0;
            busy    <= 1'b1;
            state   <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          tcnt <= tcnt + CNT_W'(1);
          if (tcnt == TCNT_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            dist_cm <= '1;
          end else if (rise) begin
            // The rising cycle itself is the first counted echo cycle
            state <= MEASURE;
            width <= CNT_W'(1);
            sub   <= SUB_W'(1);
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            // A fall on the timeout cycle still yields a valid result
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tcnt == TCNT_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            dist_cm <= '1;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
            if (width != '1) begin
              width <= width + CNT_W'(1);
            end
            if (sub == SUB_LAST) begin
              sub <= '0;
              if (dist_cm != '1) begin
                dist_cm <= dist_cm + DIST_W'(1);
              end
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_eco.sv
// Scoreboard bench for medidor_eco with a behavioural range model.
module tb_medidor_eco;

  localparam int unsigned CNT_W  = 22;
  localparam int unsigned DIST_W = 9;
  localparam int unsigned CPC    = 10;
  localparam int unsigned TMO    = 1000;
  localparam int          DMAX   = (1 << DIST_W) - 1;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              init  = 1'b0;
  logic              echo  = 1'b0;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  width;
  logic [DIST_W-1:0] dist_cm;

  medidor_eco #(
    .CNT_W      (CNT_W),
    .DIST_W     (DIST_W),
    .CYC_PER_CM (CPC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init),
    .echo    (echo),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .width   (width),
    .dist_cm (dist_cm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit tmo;
    int w;
    int d;
    int at;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: whole centimetres, saturating at the output width
  function automatic int model_dist(input int n);
    int q;
    q = n / int'(CPC);
    return (q > DMAX) ? DMAX : q;
  endfunction

  // Monitor: compare each completion against the oldest expectation
  exp_t e;
  bit   prev_done = 1'b0;
  always @(negedge clk) begin
    if (prev_done) check("done_one_cycle", done, 0);
    prev_done = rst_n && done;
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        e = sbq.pop_front();
        check("timeout", timeout, e.tmo);
        check("dist_cm", dist_cm, e.d);
        if (e.w >= 0) check("width", width, e.w);
        check("done_cycle", cyc, e.at);
        check("busy_after_done", busy, 0);
      end
    end
  end

  task automatic pulse_init(output int c);
    @(negedge clk);
    init = 1'b1;
    c = cyc;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check({nm, "_wait_bound"}, busy, 0);
    repeat (4) @(negedge clk);
  endtask

  // One echo of n cycles, starting d cycles after init; optional stray init
  task automatic measure(input int d, input int n, input bit extra_init);
    int   c;
    exp_t x;
    pulse_init(c);
    check("busy_on_accept", busy, 1);
    check("width_cleared", width, 0);
    check("dist_cleared", dist_cm, 0);
    repeat (d) @(negedge clk);
    echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      init = extra_init && (i == n / 2);
    end
    init = 1'b0;
    echo = 1'b0;
    x.tmo = 1'b0;
    x.w   = n;
    x.d   = model_dist(n);
    x.at  = cyc + 3;
    sbq.push_back(x);
    wait_idle(50, "measure");
  endtask

  task automatic expect_timeout();
    int   c;
    exp_t x;
    pulse_init(c);
    x.tmo = 1'b1;
    x.w   = 0;
    x.d   = DMAX;
    x.at  = c + 1 + int'(TMO);
    sbq.push_back(x);
    wait_idle(int'(TMO) + 50, "timeout");
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_width", width, 0);
    check("rst_dist", dist_cm, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal and floor cases
    measure(20, 100, 1'b0);
    measure(3, 29, 1'b0);
    measure(3, 9, 1'b0);

    // Echo never rises
    expect_timeout();

    // Echo already high at init is not a rise
    echo = 1'b1;
    repeat (5) @(negedge clk);
    expect_timeout();
    echo = 1'b0;
    repeat (5) @(negedge clk);
    measure(5, 50, 1'b0);

    // Stray init during MEASURE, then a fresh measurement
    measure(10, 60, 1'b1);
    measure(5, 33, 1'b0);

    // Reset mid-measurement aborts without done
    begin
      int c;
      pulse_init(c);
      repeat (10) @(negedge clk);
      echo = 1'b1;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_timeout", timeout, 0);
      check("abort_width", width, 0);
      check("abort_dist", dist_cm, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (67) @(negedge clk);
      echo = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_idle", busy, 0);
    end
    measure(5, 40, 1'b0);

    // Randomized echoes
    for (int i = 0; i < 8; i++) begin
      measure(int'($urandom_range(1, 30)), int'($urandom_range(4, 150)),
              1'($urandom_range(0, 1)));
    end

    k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/medidor_eco.md
# medidor_eco

Echo pulse-width meter for the ultrasonic ranging path. It is started by the same one-cycle `init` strobe that fires the trigger pulse generator. It then waits for the sensor's echo line to rise, counts the clock cycles the echo stays high, and converts that count to whole centimetres by incremental division. It reports completion with a one-cycle `done` pulse, or with `done` plus `timeout` if no echo completes in time.

## Interface
- `CNT_W`, 22 — width of cycle counters (`width`, timeout counter).
- `DIST_W`, 9 — width of `dist_cm`.
- `CYC_PER_CM`, 2900 — clock cycles per centimetre of range (58 µs at 50 MHz); must be ≥ 2.
- `TIMEOUT`, 1900000 — maximum cycles from `init` acceptance to a completed echo (38 ms at 50 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init`  in  1  start strobe; sampled only in IDLE.
- `echo`  in  1  raw sensor echo, asynchronous to `clk`.
- `busy`  out  1  high from the cycle after `init` acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  one-cycle pulse, coincident with `done`, when the measurement aborted.
- `width`  out  CNT_W  echo-high cycle count of the last measurement.
- `dist_cm`  out  DIST_W  floor(`width` / `CYC_PER_CM`), saturating; all-ones on timeout.

## Operation
- `echo` passes through a 2-flop synchronizer to give `echo_s`; `echo_q` is `echo_s` delayed by one cycle; `rise` = `echo_s` & ~`echo_q`.
- FSM states are IDLE, WAIT_RISE, MEASURE.
- IDLE: if `init`=1, clear `width`, `dist_cm`, the sub-counter `sub` and the timeout counter `tcnt`, then go to WAIT_RISE.
- WAIT_RISE: `tcnt`++. On `rise`: go to MEASURE with `width`<=1 and `sub`<=1. A level-high echo present at `init` is not a rise.
- MEASURE, while `echo_s`=1:
  - `tcnt`++ and `width`++, saturating at all-ones.
  - `sub`++. When `sub`==`CYC_PER_CM`-1, set `sub`<=0 and `dist_cm`++, saturating at all-ones.
- MEASURE, when `echo_s`=0: go to IDLE and set `done`<=1.
- Timeout: in WAIT_RISE or MEASURE, when `tcnt`==`TIMEOUT`-1, go to IDLE with `done`<=1, `timeout`<=1, `dist_cm`<=all-ones. `width` keeps the value it has reached.
- Simultaneous echo fall and timeout: the fall wins. The result is valid, with `timeout`=0.
- `init` while not in IDLE is ignored.
- `width` and `dist_cm` hold their values until the next accepted `init`.

## Timing
- Reset (async assert, sync-clocked release): state=IDLE. `busy`, `done`, `timeout`, `width`, `dist_cm`, `sub`, `tcnt` and all sync flops are 0.
- `busy` rises on the edge that accepts `init` and falls on the edge that raises `done`.
- `done` and `timeout` last exactly one cycle.
- For `echo` driven synchronously and high for N cycles, `width`=N.
- `done` is high during the 3rd cycle after `echo` falls: 2 synchronizer cycles plus 1 FSM cycle.
- `dist_cm` and `width` are final in the same cycle `done` is high.
- Timeout `done` is high exactly `TIMEOUT` cycles after the cycle in which `init` was accepted.
- `rst_n` low mid-measurement aborts the measurement immediately, with no `done`.

## Structure
- Shared package holds the FSM state encoding (IDLE=0, WAIT_RISE=1, MEASURE=2) and the default `CYC_PER_CM` and `TIMEOUT` constants for 50 MHz, shared with the trigger timer.
- One sub-module, `sincronizador`: 2-flop synchronizer plus edge detector, with outputs `echo_s` and `rise`. It is reused for other asynchronous sensor inputs.

## Test plan
All scenarios use `CYC_PER_CM`=10 and `TIMEOUT`=1000.

1. `init` pulse; `echo` rises 20 cycles later and stays high 100 cycles -> one `done` pulse, `width`=100, `dist_cm`=10, `timeout`=0, `busy` low after `done`.
2. Echo high 29 cycles -> `width`=29, `dist_cm`=2 (floor); echo high 9 cycles -> `dist_cm`=0.
3. `init` with `echo` never rising -> `done`=`timeout`=1 exactly 1000 cycles after acceptance, `dist_cm`=511.
4. `echo` already high when `init` arrives and staying high -> no measurement starts, timeout at 1000 cycles; then pulse `echo` low-high-low for 50 cycles after a fresh `init` -> `width`=50.
5. Second `init` during MEASURE -> ignored, and the result equals the single-`init` result. Then `init` after `done` -> new measurement with cleared outputs.
6. `rst_n` asserted 30 cycles into a 100-cycle echo -> all outputs 0 immediately, no `done`. After release, a new 40-cycle measurement gives `width`=40, `dist_cm`=4.
